// File: rtl/bram_sdp_init.sv
// Simple dual-port block RAM: one byte-masked write port and one read port,
// with optional zero-fill after reset and a 1- or 2-cycle registered read path.
module bram_sdp_init #(
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned AWIDTH         = 8,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AWIDTH-1:0]     wr_addr,
    input  logic [DWIDTH-1:0]     din,
    input  logic [DWIDTH/8-1:0]   wr_be,
    input  logic                  re,
    input  logic [AWIDTH-1:0]     rd_addr,
    output logic [DWIDTH-1:0]     dout,
    output logic                  dout_valid,
    output logic                  init_busy
);

    localparam int unsigned NBYTES = DWIDTH / 8;
    localparam int unsigned DEPTH  = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] LAST_ADDR = {AWIDTH{1'b1}};

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic [AWIDTH-1:0]   clear_addr_q, clear_addr_d;
    logic                clear_we_c;
    logic                wr_en_c;
    logic                rd_en_c;
    logic [DWIDTH-1:0]   rd_word_c;
    logic [DWIDTH-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic [DWIDTH-1:0]   mem [DEPTH];

    // busy_q doubles as the fill arm: the first post-reset cycle only raises it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            busy_q       <= 1'b0;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = 1'b0;
        clear_addr_d = clear_addr_q;
        clear_we_c   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy_d = 1'b1;
                if (busy_q && !reset) begin
                    clear_we_c   = 1'b1;
                    clear_addr_d = clear_addr_q + AWIDTH'(1);
                    if (clear_addr_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    assign wr_en_c   = (state_q == ST_RUN) && we && !reset;
    assign rd_en_c   = (state_q == ST_RUN) && re;
    assign init_busy = busy_q;

    always_ff @(posedge clk) begin
        if (clear_we_c) begin
            mem[clear_addr_q] <= '0;
        end else if (wr_en_c) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    // Same-address collision in new-data mode forwards the enabled din bytes
    always_comb begin
        rd_word_c = mem[rd_addr];
        if ((RDW_MODE != 0) && wr_en_c && (wr_addr == rd_addr)) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    rd_word_c[8*i +: 8] = din[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_c;
            if (rd_en_c) begin
                rd_data_q <= rd_word_c;
            end
        end
    end

    generate
        if (RD_LATENCY >= 2) begin : g_out_reg
            logic [DWIDTH-1:0] out_data_q;
            logic              out_valid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_data_q  <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= rd_valid_q;
                    if (rd_valid_q) begin
                        out_data_q <= rd_data_q;
                    end
                end
            end

            assign dout       = out_data_q;
            assign dout_valid = out_valid_q;
        end else begin : g_direct
            assign dout       = rd_data_q;
            assign dout_valid = rd_valid_q;
        end
    endgenerate

endmodule
